// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues credit-limited memory reads
// and buffers returned instructions with their PCs in a show-ahead FIFO.
module fetch_queue #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                INC      = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDR_W-1:0]            o_pc_addr,
    output logic                         o_pc_rd,
    input  logic [DATA_W-1:0]            i_pc_rddata,
    input  logic                         i_redirect,
    input  logic [ADDR_W-1:0]            i_redirect_pc,
    output logic [DATA_W-1:0]            o_inst,
    output logic [ADDR_W-1:0]            o_inst_pc,
    output logic                         o_inst_valid,
    input  logic                         i_inst_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic              rsp_pending;
    logic [DATA_W-1:0] buf_data [DEPTH];
    logic [ADDR_W-1:0] buf_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    credits_used;
    logic              fire;
    logic              push;
    logic              pop;

    // A slot is reserved for every outstanding read, so the FIFO can never overflow.
    always_comb begin
        credits_used = {1'b0, count} + {{CNT_W{1'b0}}, rsp_pending};
        fire         = !reset && !i_redirect && (credits_used < (CNT_W+1)'(DEPTH));
        push         = rsp_pending && !i_redirect;
        pop          = (count != '0) && i_inst_ready && !i_redirect;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            rsp_pc      <= '0;
            rsp_pending <= 1'b0;
        end else if (i_redirect) begin
            pc          <= i_redirect_pc;
            rsp_pending <= 1'b0;
        end else begin
            rsp_pending <= fire;
            if (fire) begin
                pc     <= pc + ADDR_W'(INC);
                rsp_pc <= pc;
            end
        end
    end

    // Redirect empties the queue outright; any in-flight response is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (i_redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (push) begin
            buf_data[wr_ptr] <= i_pc_rddata;
            buf_pc[wr_ptr]   <= rsp_pc;
        end
    end

    assign o_pc_addr    = pc;
    assign o_pc_rd      = fire;
    assign o_inst       = buf_data[rd_ptr];
    assign o_inst_pc    = buf_pc[rd_ptr];
    assign o_inst_valid = (count != '0);
    assign o_count      = count;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the pipelined CPU. It owns the program counter, issues reads to instruction memory under a credit limit, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. The FIFO presents a valid/ready stream to decode, so back-pressure, stalls and branch redirects (with flush of in-flight fetches) are handled in one place rather than by freezing pipeline registers.

## Interface
- DATA_W, 16, instruction width
- ADDR_W, 16, PC/address width
- DEPTH, 4, FIFO entries; power of 2, ≥2 (≥3 needed for 1 instr/cycle)
- RESET_PC, 0, PC value after reset
- INC, 2, PC increment per fetch

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- o_pc_addr  out  ADDR_W  fetch address (= PC register)
- o_pc_rd  out  1  fetch request this cycle
- i_pc_rddata  in  DATA_W  memory data, valid the cycle after o_pc_rd was high
- i_redirect  in  1  branch/jump taken; flush and reload PC
- i_redirect_pc  in  ADDR_W  new PC, sampled with i_redirect
- o_inst  out  DATA_W  FIFO head instruction
- o_inst_pc  out  ADDR_W  PC of FIFO head
- o_inst_valid  out  1  head valid (count ≠ 0)
- i_inst_ready  in  1  decode accepts head this cycle
- o_count  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- State: pc, rsp_pending (1 b), rsp_pc, FIFO storage (data+pc per entry), rd_ptr, wr_ptr ($clog2(DEPTH) b, natural wrap), count.
- Request: o_pc_rd = !reset & !i_redirect & (count + rsp_pending < DEPTH). o_pc_addr = pc always.
- Fire (o_pc_rd high at edge): pc ← pc + INC mod 2^ADDR_W; rsp_pending ← 1; rsp_pc ← pc. No fire: rsp_pending ← 0.
- Push: when rsp_pending & !i_redirect, write {i_pc_rddata, rsp_pc} at wr_ptr, wr_ptr++.
- Pop: when o_inst_valid & i_inst_ready & !i_redirect, rd_ptr++.
- count ← count + push − pop; push and pop in the same cycle leave count unchanged.
- Redirect (highest priority): pc ← i_redirect_pc; rd_ptr, wr_ptr, count ← 0; pending response discarded; pop ignored; no request this cycle.
- Overflow impossible by credit rule; push when full is a design error (assertion in bench).
- o_inst/o_inst_pc show-ahead from storage[rd_ptr]; contents undefined-but-stable when !o_inst_valid (storage reset to 0).

## Timing
- Reset values: pc=RESET_PC, rsp_pending=0, count=0, pointers=0, storage=0; hence o_pc_rd=0 while reset, o_pc_addr=RESET_PC, o_inst=0, o_inst_pc=0, o_inst_valid=0, o_count=0.
- Memory latency fixed at 1: request in cycle c → data in c+1 → entry visible at o_inst in c+2.
- First cycle after reset release: o_pc_rd=1, o_pc_addr=RESET_PC; that instruction valid at o_inst two cycles later.
- Redirect asserted in cycle c: o_inst_valid=0 in c+1; request for i_redirect_pc in c+1; that instruction valid at o_inst in c+3 (redirect penalty 2 bubbles after the redirect cycle).
- Steady state with ready high and DEPTH≥3: one fire, one push, one pop per cycle, consecutive PCs.
- Ready low: requests stop once count + rsp_pending = DEPTH; exactly DEPTH entries held; first request reissues the cycle after a pop reduces the sum below DEPTH.
- Reset mid-operation: all state cleared asynchronously, in-flight data on i_pc_rddata ignored; restart from RESET_PC.

## Test plan
- Reset release, memory returns 16'h1000+addr, ready=1, DEPTH=4 -> o_pc_addr 0,2,4,… each cycle; o_inst 16'h1000 with o_inst_pc 0 two cycles after release, then 16'h1002, 16'h1004 back-to-back.
- Ready held low 10 cycles -> exactly 4 fires (PCs 0,2,4,6), o_count=4, o_pc_rd=0; ready high -> entries pop in order 0,2,4,6, fetch resumes at 8 with no gap or duplicate.
- i_redirect with i_redirect_pc=16'h0040 while FIFO holds 3 entries and one response pending -> o_inst_valid=0 next cycle, pending data never appears, o_inst_pc=16'h0040 valid 3 cycles after redirect, then 16'h0042.
- Redirect in same cycle as full FIFO and ready=1 -> no pop counted, o_count=0 next cycle, new stream starts at redirect PC.
- RESET_PC=16'hFFFC, ADDR_W=16 -> fetch addresses FFFC, FFFE, 0000, 0002; o_inst_pc shows same wrap.
- reset pulsed while count=3 and a response pending -> outputs at reset values immediately; after release first fetch at RESET_PC, no stale entry delivered.
